// File: rtl/matrix_input_buffer.sv
// Double-buffered N x N matrix store: rows are written in row-major order into one
// bank while the other bank is read out as column or row vectors, one element per cycle.
module matrix_input_buffer #(
   parameter int DATA_WIDTH = 16,
   parameter int N          = 3,
   parameter int TIMEOUT_EN = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] A_i,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   output logic                  done_load,
   input  logic                  start_read,
   input  logic                  rd_mode,
   output logic [DATA_WIDTH-1:0] A_o,
   output logic                  rd_valid,
   output logic                  done_read_vector,
   output logic                  done_matrix,
   output logic                  overflow
);

   localparam int DEPTH = N * N;
   localparam int AW    = $clog2(DEPTH);
   localparam int CW    = $clog2(N);

   typedef enum logic {IDLE, READ} state_t;

   // Reserved hook; intentionally empty.
   if (TIMEOUT_EN != 0) begin : g_timeout_rsvd
   end

   state_t                  state;
   logic [DATA_WIDTH-1:0]   mem [2][DEPTH];
   logic [1:0]              full;
   logic                    wr_bank;
   logic                    rd_bank;
   logic                    mode_q;
   logic [AW-1:0]           wr_idx;
   logic [AW-1:0]           rd_addr;
   logic [CW-1:0]           vec_idx;
   logic [CW-1:0]           elem_idx;
   logic                    wr_en;
   logic                    wr_last;
   logic                    rd_last_elem;
   logic                    rd_last_vec;

   assign wr_ready     = ~full[wr_bank];
   assign wr_en        = wr_valid & wr_ready;
   assign wr_last      = (wr_idx == AW'(DEPTH - 1));
   assign rd_last_elem = (elem_idx == CW'(N - 1));
   assign rd_last_vec  = (vec_idx == CW'(N - 1));

   // Row mode walks along row vec_idx; column mode walks down column vec_idx.
   always_comb begin
      rd_addr = '0;
      if (mode_q)
         rd_addr = AW'(32'(vec_idx) * N + 32'(elem_idx));
      else
         rd_addr = AW'(32'(elem_idx) * N + 32'(vec_idx));
   end

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_bank][wr_idx] <= A_i;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state            <= IDLE;
         full             <= '0;
         wr_bank          <= 1'b0;
         rd_bank          <= 1'b0;
         wr_idx           <= '0;
         vec_idx          <= '0;
         elem_idx         <= '0;
         mode_q           <= 1'b0;
         A_o              <= '0;
         rd_valid         <= 1'b0;
         done_load        <= 1'b0;
         done_read_vector <= 1'b0;
         done_matrix      <= 1'b0;
         overflow         <= 1'b0;
      end else begin
         done_load        <= 1'b0;
         rd_valid         <= 1'b0;
         done_read_vector <= 1'b0;
         done_matrix      <= 1'b0;

         if (wr_valid && !wr_ready)
            overflow <= 1'b1;

         if (wr_en) begin
            if (wr_last) begin
               full[wr_bank] <= 1'b1;
               wr_idx        <= '0;
               wr_bank       <= ~wr_bank;
               done_load     <= 1'b1;
            end else begin
               wr_idx <= wr_idx + 1'b1;
            end
         end

         // Write-complete and read-free always target different banks, so both
         // full-flag updates can land in the same cycle.
         case (state)
            IDLE: begin
               if (start_read && full[rd_bank]) begin
                  state    <= READ;
                  elem_idx <= '0;
                  if (vec_idx == '0)
                     mode_q <= rd_mode;
               end
            end
            READ: begin
               A_o      <= mem[rd_bank][rd_addr];
               rd_valid <= 1'b1;
               if (rd_last_elem) begin
                  done_read_vector <= 1'b1;
                  state            <= IDLE;
                  elem_idx         <= '0;
                  if (rd_last_vec) begin
                     done_matrix   <= 1'b1;
                     full[rd_bank] <= 1'b0;
                     vec_idx       <= '0;
                     rd_bank       <= ~rd_bank;
                  end else begin
                     vec_idx <= vec_idx + 1'b1;
                  end
               end else begin
                  elem_idx <= elem_idx + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_matrix_input_buffer.sv
// Scoreboard bench for matrix_input_buffer (N=3, 16-bit): stimulus pushes expected
// read-out, a negedge monitor pops and compares every rd_valid beat.
module tb_matrix_input_buffer;

   logic        clk;
   logic        reset;
   logic [15:0] A_i;
   logic        wr_valid;
   logic        wr_ready;
   logic        done_load;
   logic        start_read;
   logic        rd_mode;
   logic [15:0] A_o;
   logic        rd_valid;
   logic        done_read_vector;
   logic        done_matrix;
   logic        overflow;

   matrix_input_buffer #(.DATA_WIDTH(16), .N(3), .TIMEOUT_EN(0)) dut (
      .clk(clk), .reset(reset), .A_i(A_i), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .done_load(done_load), .start_read(start_read), .rd_mode(rd_mode), .A_o(A_o),
      .rd_valid(rd_valid), .done_read_vector(done_read_vector), .done_matrix(done_matrix),
      .overflow(overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] data;
      logic        dv;
      logic        dm;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   dl_cnt = 0;
   int   rv_cnt = 0;
   int   dv_cnt = 0;
   int   dm_cnt = 0;

   // Column read-out order of a row-major 3x3 matrix, as offsets from element (0,0).
   int col_ord[9] = '{0, 3, 6, 1, 4, 7, 2, 5, 8};

   always @(negedge clk) begin
      if (done_load) dl_cnt++;
      if (rd_valid) begin
         exp_t e;
         rv_cnt++;
         if (done_read_vector) dv_cnt++;
         if (done_matrix) dm_cnt++;
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL rd_unexpected: got A_o=%0d dv=%0b dm=%0b, expected no output", A_o,
                     done_read_vector, done_matrix);
         end else begin
            e = exp_q.pop_front();
            if (A_o !== e.data || done_read_vector !== e.dv || done_matrix !== e.dm) begin
               n_bad++;
               $display("FAIL rd_beat: got A_o=%0d dv=%0b dm=%0b, expected A_o=%0d dv=%0b dm=%0b",
                        A_o, done_read_vector, done_matrix, e.data, e.dv, e.dm);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic push_mat(input int base, input bit row);
      exp_t e;
      for (int i = 0; i < 9; i++) begin
         e.data = 16'(row ? base + i : base + col_ord[i]);
         e.dv   = (i % 3 == 2);
         e.dm   = (i == 8);
         exp_q.push_back(e);
      end
   endtask

   task automatic do_reset();
      start_read = 1'b0;
      wr_valid   = 1'b0;
      A_i        = '0;
      reset      = 1'b0;
      #1;
      check("rst_wr_ready", wr_ready, 1);
      check("rst_rd_valid", rd_valid, 0);
      check("rst_A_o", A_o, 0);
      check("rst_done_load", done_load, 0);
      check("rst_done_vec", done_read_vector, 0);
      check("rst_done_matrix", done_matrix, 0);
      check("rst_overflow", overflow, 0);
      exp_q.delete();
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic write_matrix(input int base);
      for (int i = 0; i < 9; i++) begin
         A_i      = 16'(base + i);
         wr_valid = 1'b1;
         @(posedge clk); #1;
      end
      wr_valid = 1'b0;
      check("done_load_after_9th", done_load, 1);
      @(posedge clk); #1;
      check("done_load_one_cycle", done_load, 0);
   endtask

   task automatic read_matrices(input int cnt);
      int target;
      target     = dm_cnt + cnt;
      start_read = 1'b1;
      for (int c = 0; c < 200 && dm_cnt < target; c++) begin
         @(posedge clk); #1;
      end
      start_read = 1'b0;
      if (dm_cnt < target) begin
         n_cmp++;
         n_bad++;
         $display("FAIL read_timeout: got %0d done_matrix, expected %0d", dm_cnt, target);
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      int dl0, dm0, dv0;
      reset      = 1'b0;
      A_i        = '0;
      wr_valid   = 1'b0;
      start_read = 1'b0;
      rd_mode    = 1'b0;
      #3;
      do_reset();

      // V4 + V1: read request with nothing loaded, then column read-out of 1..9
      start_read = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("no_read_when_empty", rv_cnt, 0);
      push_mat(1, 1'b0);
      write_matrix(1);
      read_matrices(1);
      check("v1_done_load_cnt", dl_cnt, 1);

      // V2: row mode, rd_mode flipped mid-matrix must be ignored
      rd_mode = 1'b1;
      push_mat(11, 1'b1);
      write_matrix(11);
      fork
         begin
            repeat (6) @(posedge clk);
            #1 rd_mode = 1'b0;
         end
      join_none
      read_matrices(1);

      // V3: fill both banks, then an extra write overflows and is dropped
      rd_mode = 1'b0;
      push_mat(21, 1'b0);
      push_mat(31, 1'b0);
      write_matrix(21);
      write_matrix(31);
      check("v3_wr_ready_full", wr_ready, 0);
      check("v3_done_load_cnt", dl_cnt, 4);
      check("v3_overflow_before", overflow, 0);
      A_i      = 16'd99;
      wr_valid = 1'b1;
      @(posedge clk); #1;
      wr_valid = 1'b0;
      check("v3_overflow_set", overflow, 1);
      repeat (3) @(posedge clk);
      #1;
      check("v3_overflow_sticky", overflow, 1);
      read_matrices(2);
      check("v3_overflow_after_read", overflow, 1);
      check("v3_wr_ready_free", wr_ready, 1);

      // V5: read one bank while the other is loaded
      push_mat(41, 1'b0);
      push_mat(51, 1'b0);
      write_matrix(41);
      dl0 = dl_cnt;
      dm0 = dm_cnt;
      fork
         write_matrix(51);
         read_matrices(2);
      join
      check("v5_done_load_cnt", dl_cnt - dl0, 1);
      check("v5_done_matrix_cnt", dm_cnt - dm0, 2);

      // V6: reset during the second vector, then a fresh load reads from (0,0)
      push_mat(61, 1'b0);
      write_matrix(61);
      dv0        = dv_cnt;
      start_read = 1'b1;
      for (int c = 0; c < 50 && dv_cnt == dv0; c++) begin
         @(posedge clk); #1;
      end
      check("v6_first_vector_done", dv_cnt - dv0, 1);
      repeat (2) @(posedge clk);
      #1;
      do_reset();
      push_mat(71, 1'b0);
      write_matrix(71);
      read_matrices(1);

      check("queue_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
